// File: rtl/mem_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mem_ctrl_pkg -- shared CPU definitions: bus FSM states, access sizes, I/O decode
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    LS_RD = 2'd2,
    LS_WR = 2'd3
  } state_t;

  localparam logic [2:0] SIZE_B = 3'd1;
  localparam logic [2:0] SIZE_H = 3'd2;
  localparam logic [2:0] SIZE_W = 3'd4;

  // Top two RAM address bits equal to this select the I/O space
  localparam logic [1:0] IO_SPACE = 2'b11;

  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    case (size)
      SIZE_B:  return SIZE_B;
      SIZE_H:  return SIZE_H;
      default: return SIZE_W;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_ctrl.sv
// ----------------------------------------------------------------------------
// mem_ctrl -- round-robin ifetch/LSB arbiter and byte-serial memory sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 17
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clr_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  output logic        if_done_out,
  output logic [31:0] if_data_out,
  input  logic        lsb_req_in,
  input  logic        lsb_wr_in,
  input  logic [31:0] lsb_addr_in,
  input  logic [2:0]  lsb_size_in,
  input  logic [31:0] lsb_data_in,
  output logic        lsb_done_out,
  output logic [31:0] lsb_data_out,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_t      state, state_d;
  logic [31:0] mem_a_d;
  logic        mem_wr_d;
  logic [7:0]  mem_dout_d;
  logic        if_done_d, lsb_done_d;
  logic [31:0] if_data_d, lsb_data_d;
  logic [31:0] rd_buf, rd_buf_d;
  logic [2:0]  cnt, cnt_d;          // bytes captured (read) or written (store)
  logic [2:0]  iss_cnt, iss_cnt_d;  // read addresses issued
  logic        iss, iss_d;          // mem_a carries a live read address this cycle
  logic        prev, prev_d;        // ...and did so last cycle, so mem_din is valid
  logic        lsb_next, lsb_next_d;

  logic        lsb_io, if_ok, ls_ok, grant_ls, grant_if, rd_last;
  logic [2:0]  nbytes, cnt_inc, wr_cnt;
  logic [31:0] rd_addr;

  assign lsb_io   = (lsb_addr_in[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1] == IO_SPACE);
  // A requester that is seeing its own done pulse has not yet dropped req
  assign if_ok    = if_req_in && !if_done_out && !clr_in;
  assign ls_ok    = lsb_req_in && !lsb_done_out && (!clr_in || lsb_wr_in);
  assign grant_ls = ls_ok && (!if_ok || lsb_next);
  assign grant_if = if_ok && !grant_ls;
  assign nbytes   = (state == IF_RD) ? SIZE_W : size_bytes(lsb_size_in);
  assign rd_addr  = (state == IF_RD) ? if_addr_in : lsb_addr_in;
  assign cnt_inc  = cnt + 3'd1;
  assign wr_cnt   = cnt + {2'd0, mem_wr};
  assign rd_last  = prev && (cnt_inc == nbytes);

  always_comb begin
    state_d    = state;
    mem_a_d    = '0;
    mem_wr_d   = 1'b0;
    mem_dout_d = '0;
    if_done_d  = 1'b0;
    lsb_done_d = 1'b0;
    if_data_d  = if_data_out;
    lsb_data_d = lsb_data_out;
    rd_buf_d   = rd_buf;
    cnt_d      = cnt;
    iss_cnt_d  = iss_cnt;
    iss_d      = 1'b0;
    prev_d     = 1'b0;
    lsb_next_d = lsb_next;

    case (state)
      IDLE: begin
        if (rdy_in && grant_if) begin
          state_d    = IF_RD;
          mem_a_d    = if_addr_in;
          iss_cnt_d  = 3'd1;
          iss_d      = 1'b1;
          cnt_d      = '0;
          rd_buf_d   = '0;
          lsb_next_d = 1'b1;
        end else if (rdy_in && grant_ls) begin
          cnt_d      = '0;
          rd_buf_d   = '0;
          lsb_next_d = 1'b0;
          if (lsb_wr_in) begin
            state_d = LS_WR;
            if (!lsb_io || !io_buffer_full) begin
              mem_a_d    = lsb_addr_in;
              mem_wr_d   = 1'b1;
              mem_dout_d = lsb_data_in[7:0];
            end
          end else begin
            state_d   = LS_RD;
            mem_a_d   = lsb_addr_in;
            iss_cnt_d = 3'd1;
            iss_d     = 1'b1;
          end
        end
      end

      IF_RD, LS_RD: begin
        if (clr_in) begin
          state_d   = IDLE;
          cnt_d     = '0;
          iss_cnt_d = '0;
        end else if (!rdy_in) begin
          // Hold the oldest uncaptured byte's address so it is re-issued on resume
          mem_a_d   = rd_addr + {29'd0, cnt};
          iss_cnt_d = cnt_inc;
          iss_d     = 1'b1;
        end else begin
          prev_d = iss;
          if (prev) begin
            rd_buf_d[{cnt[1:0], 3'b000} +: 8] = mem_din;
            cnt_d = cnt_inc;
          end
          if (rd_last) begin
            state_d   = IDLE;
            cnt_d     = '0;
            iss_cnt_d = '0;
            prev_d    = 1'b0;
            if (state == IF_RD) begin
              if_done_d = 1'b1;
              if_data_d = rd_buf_d;
            end else begin
              lsb_done_d = 1'b1;
              lsb_data_d = rd_buf_d;
            end
          end else if (iss_cnt < nbytes) begin
            mem_a_d   = rd_addr + {29'd0, iss_cnt};
            iss_cnt_d = iss_cnt + 3'd1;
            iss_d     = 1'b1;
          end
        end
      end

      LS_WR: begin
        if (rdy_in) begin
          if (wr_cnt == nbytes) begin
            state_d    = IDLE;
            lsb_done_d = 1'b1;
            cnt_d      = '0;
          end else begin
            cnt_d = wr_cnt;
            // I/O bytes need buffer space and a gap cycle after the previous I/O write
            if (!lsb_io || (!io_buffer_full && !mem_wr)) begin
              mem_a_d    = lsb_addr_in + {29'd0, wr_cnt};
              mem_wr_d   = 1'b1;
              mem_dout_d = lsb_data_in[{wr_cnt[1:0], 3'b000} +: 8];
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= IDLE;
      mem_a        <= '0;
      mem_wr       <= 1'b0;
      mem_dout     <= '0;
      if_done_out  <= 1'b0;
      lsb_done_out <= 1'b0;
      if_data_out  <= '0;
      lsb_data_out <= '0;
      rd_buf       <= '0;
      cnt          <= '0;
      iss_cnt      <= '0;
      iss          <= 1'b0;
      prev         <= 1'b0;
      lsb_next     <= 1'b1;
    end else begin
      state        <= state_d;
      mem_a        <= mem_a_d;
      mem_wr       <= mem_wr_d;
      mem_dout     <= mem_dout_d;
      if_done_out  <= if_done_d;
      lsb_done_out <= lsb_done_d;
      if_data_out  <= if_data_d;
      lsb_data_out <= lsb_data_d;
      rd_buf       <= rd_buf_d;
      cnt          <= cnt_d;
      iss_cnt      <= iss_cnt_d;
      iss          <= iss_d;
      prev         <= prev_d;
      lsb_next     <= lsb_next_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_ctrl -- directed self-checking bench for mem_ctrl with a byte RAM model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        clr_in = 1'b0;
  logic        if_req_in = 1'b0;
  logic [31:0] if_addr_in = '0;
  logic        if_done_out;
  logic [31:0] if_data_out;
  logic        lsb_req_in = 1'b0;
  logic        lsb_wr_in = 1'b0;
  logic [31:0] lsb_addr_in = '0;
  logic [2:0]  lsb_size_in = '0;
  logic [31:0] lsb_data_in = '0;
  logic        lsb_done_out;
  logic [31:0] lsb_data_out;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [7:0] wmem   [0:131071];
  bit         wvalid [0:131071];

  mem_ctrl #(.RAM_ADDR_WIDTH(17)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in),
    .if_done_out(if_done_out), .if_data_out(if_data_out),
    .lsb_req_in(lsb_req_in), .lsb_wr_in(lsb_wr_in), .lsb_addr_in(lsb_addr_in),
    .lsb_size_in(lsb_size_in), .lsb_data_in(lsb_data_in),
    .lsb_done_out(lsb_done_out), .lsb_data_out(lsb_data_out),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  // Preloaded RAM image; bytes written by the DUT override it
  function automatic logic [7:0] rom(input logic [16:0] a);
    case (a)
      17'h01000: return 8'h13;
      17'h01001: return 8'h05;
      17'h00040: return 8'hF5;
      17'h00041: return 8'h77;
      17'h00100: return 8'h11;
      17'h00101: return 8'h22;
      17'h00102: return 8'h33;
      17'h00103: return 8'h44;
      17'h1FFFF: return 8'h5A;
      17'h00000: return 8'hC3;
      default:   return 8'h00;
    endcase
  endfunction

  // Synchronous byte RAM; while the host holds the bus its read data is garbage
  always @(posedge clk_in) begin
    if (mem_wr) begin
      wmem[mem_a[16:0]]   <= mem_dout;
      wvalid[mem_a[16:0]] <= 1'b1;
    end
    mem_din <= !rdy_in ? 8'hEE :
               (wvalid[mem_a[16:0]] ? wmem[mem_a[16:0]] : rom(mem_a[16:0]));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic ls_req(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] d);
    lsb_req_in  = 1'b1;
    lsb_wr_in   = wr;
    lsb_addr_in = a;
    lsb_size_in = sz;
    lsb_data_in = d;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] want, input int lat);
    ls_req(1'b0, a, sz, 32'h0);
    for (int c = 1; c <= lat; c++) begin
      tick();
      if (c == 1) check("ld_addr0", mem_a, a);
      check("ld_done", 32'(lsb_done_out), 32'(c == lat));
      if (c == lat) check("ld_data", lsb_data_out, want);
    end
    lsb_req_in = 1'b0;
    tick();
  endtask

  initial begin
    logic [3:0] order;
    int         n;
    bit         raise_l, raise_i;

    rst_in = 1'b1;
    repeat (2) tick();
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_ctrl", 32'({mem_wr, if_done_out, lsb_done_out, mem_dout}), 32'h0);
    check("rst_data", if_data_out | lsb_data_out, 32'h0);
    rst_in = 1'b0;
    tick();

    // Word fetch from 0x1000: bytes addressed G+1..G+4, done at G+6
    if_addr_in = 32'h1000;
    if_req_in  = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c <= 4) check("if_addr", mem_a, 32'h1000 + 32'(c - 1));
      check("if_done", 32'(if_done_out), 32'(c == 6));
      if (c == 6) begin
        check("if_data", if_data_out, 32'h0000_0513);
        if_req_in = 1'b0;
      end
    end

    // Halfword store, little-endian bytes, done at G+3
    ls_req(1'b1, 32'h20, 3'd2, 32'hABCD_1234);
    tick();
    check("st_b0_a", mem_a, 32'h20);
    check("st_b0_d", 32'({mem_wr, mem_dout}), 32'h134);
    tick();
    check("st_b1_a", mem_a, 32'h21);
    check("st_b1_d", 32'({mem_wr, mem_dout}), 32'h112);
    tick();
    check("st_done", 32'({lsb_done_out, mem_wr}), 32'h2);
    lsb_req_in = 1'b0;
    tick();
    check("st_mem", 32'({wmem[17'h21], wmem[17'h20]}), 32'h1234);

    // Loads: zero extension, wrap past 0xFFFFFFFF, word
    do_load(32'h40, 3'd1, 32'h0000_00F5, 3);
    do_load(32'h40, 3'd2, 32'h0000_77F5, 4);
    do_load(32'hFFFF_FFFF, 3'd2, 32'h0000_C35A, 4);
    do_load(32'h100, 3'd4, 32'h4433_2211, 6);

    // I/O store held off while the host buffer is full (cycles G..G+4)
    io_buffer_full = 1'b1;
    ls_req(1'b1, 32'h0003_0000, 3'd1, 32'h41);
    for (int c = 1; c <= 5; c++) begin
      tick();
      check("io_hold_wr", 32'(mem_wr), 32'h0);
      check("io_hold_a", mem_a, 32'h0);
      if (c == 5) io_buffer_full = 1'b0;
    end
    tick();
    check("io_wr_a", mem_a, 32'h0003_0000);
    check("io_wr_d", 32'({mem_wr, mem_dout}), 32'h141);
    tick();
    check("io_done", 32'(lsb_done_out), 32'h1);
    lsb_req_in = 1'b0;
    tick();

    // Word load with rdy_in low for three cycles
    ls_req(1'b0, 32'h100, 3'd4, 32'h0);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 3) rdy_in = 1'b0;
      if (c == 6) begin
        rdy_in = 1'b1;
        check("stall_reissue", mem_a, 32'h101);
      end
      check("stall_done", 32'(lsb_done_out), 32'(c == 10));
      if (c == 10) check("stall_data", lsb_data_out, 32'h4433_2211);
    end
    lsb_req_in = 1'b0;
    tick();

    // Flush during ifetch at byte 2 aborts it
    if_addr_in = 32'h1000;
    if_req_in  = 1'b1;
    repeat (3) tick();
    check("clr_if_a2", mem_a, 32'h1002);
    clr_in    = 1'b1;
    if_req_in = 1'b0;
    tick();
    check("clr_if_a0", mem_a, 32'h0);
    clr_in = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("clr_if_nodone", 32'(if_done_out), 32'h0);
    end

    // Flush during a store does not stop it
    ls_req(1'b1, 32'h50, 3'd4, 32'hDEAD_BEEF);
    tick();
    clr_in = 1'b1;
    tick();
    clr_in = 1'b0;
    check("clr_st_a", mem_a, 32'h51);
    check("clr_st_wr", 32'(mem_wr), 32'h1);
    repeat (3) tick();
    check("clr_st_done", 32'(lsb_done_out), 32'h1);
    lsb_req_in = 1'b0;
    tick();
    check("clr_st_mem", {wmem[17'h53], wmem[17'h52], wmem[17'h51], wmem[17'h50]},
          32'hDEAD_BEEF);

    // Flush in IDLE blocks an ifetch grant but not a store grant
    if_addr_in = 32'h1000;
    if_req_in  = 1'b1;
    clr_in     = 1'b1;
    tick();
    check("clr_idle_if", mem_a, 32'h0);
    clr_in = 1'b0;
    for (int c = 2; c <= 7; c++) begin
      tick();
      if (c == 2) check("clr_idle_if_late", mem_a, 32'h1000);
      if (c == 7) begin
        check("clr_idle_if_done", 32'(if_done_out), 32'h1);
        if_req_in = 1'b0;
      end
    end
    tick();
    ls_req(1'b1, 32'h60, 3'd1, 32'h99);
    clr_in = 1'b1;
    tick();
    clr_in = 1'b0;
    check("clr_idle_st_a", mem_a, 32'h60);
    check("clr_idle_st_wr", 32'(mem_wr), 32'h1);
    tick();
    check("clr_idle_st_done", 32'(lsb_done_out), 32'h1);
    lsb_req_in = 1'b0;
    tick();

    // Asynchronous reset mid-load: outputs clear without an edge, no done afterwards
    ls_req(1'b0, 32'h100, 3'd4, 32'h0);
    repeat (2) tick();
    #2 rst_in = 1'b1;
    #1;
    check("arst_mem_a", mem_a, 32'h0);
    lsb_req_in = 1'b0;
    tick();
    rst_in = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("arst_nodone", 32'(lsb_done_out), 32'h0);
    end

    // Round robin with both requesting continuously; LSB first after reset
    order   = '0;
    n       = 0;
    raise_l = 1'b0;
    raise_i = 1'b0;
    ls_req(1'b0, 32'h40, 3'd1, 32'h0);
    if_addr_in = 32'h1000;
    if_req_in  = 1'b1;
    for (int c = 0; c < 80 && n < 4; c++) begin
      tick();
      if (raise_l) begin lsb_req_in = 1'b1; raise_l = 1'b0; end
      if (raise_i) begin if_req_in = 1'b1; raise_i = 1'b0; end
      if (lsb_done_out) begin
        check("rr_lsb_data", lsb_data_out, 32'h0000_00F5);
        order      = {order[2:0], 1'b1};
        n++;
        lsb_req_in = 1'b0;
        raise_l    = 1'b1;
      end
      if (if_done_out) begin
        check("rr_if_data", if_data_out, 32'h0000_0513);
        order     = {order[2:0], 1'b0};
        n++;
        if_req_in = 1'b0;
        raise_i   = 1'b1;
      end
    end
    lsb_req_in = 1'b0;
    if_req_in  = 1'b0;
    check("rr_count", 32'(n), 32'd4);
    check("rr_order", 32'(order), 32'hA);
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
